// File: rtl/hit_stay_conditioner.sv
// Player-input conditioner: synchronises, debounces and arbitrates the active-low Hit/Stay
// buttons and emits one single-cycle pulse per accepted press while the game enables a decision.
module hit_stay_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic i_Hit_n,
  input  logic i_Stay_n,
  input  logic i_Enable,
  output logic o_HitPulse,
  output logic o_StayPulse,
  output logic o_Conflict,
  output logic o_Armed
);

  typedef enum logic [1:0] {
    StWaitRelease = 2'd0,
    StArmed       = 2'd1,
    StFireHit     = 2'd2,
    StFireStay    = 2'd3
  } state_e;

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] hit_sync_q, stay_sync_q;
  logic                   hit_synced, stay_synced;

  // Stable levels are kept active-low: 1 = released.
  logic       hit_stable_q, hit_stable_d;
  logic       stay_stable_q, stay_stable_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] stay_cnt_q, stay_cnt_d;

  state_e state_q, state_d;
  logic   conflict_q, conflict_d;
  logic   hit_pressed, stay_pressed;

  // Synchronisers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_sync_q  <= '1;
      stay_sync_q <= '1;
    end else begin
      hit_sync_q  <= {hit_sync_q[SYNC_STAGES-2:0], i_Hit_n};
      stay_sync_q <= {stay_sync_q[SYNC_STAGES-2:0], i_Stay_n};
    end
  end

  assign hit_synced  = hit_sync_q[SYNC_STAGES-1];
  assign stay_synced = stay_sync_q[SYNC_STAGES-1];

  // Any return to the stable level restarts the count, so short glitches are dropped.
  always_comb begin
    hit_stable_d = hit_stable_q;
    hit_cnt_d    = hit_cnt_q;
    if (hit_synced != hit_stable_q) begin
      if (hit_cnt_q >= CntLast) begin
        hit_stable_d = hit_synced;
        hit_cnt_d    = '0;
      end else begin
        hit_cnt_d = hit_cnt_q + 8'd1;
      end
    end else begin
      hit_cnt_d = '0;
    end
  end

  always_comb begin
    stay_stable_d = stay_stable_q;
    stay_cnt_d    = stay_cnt_q;
    if (stay_synced != stay_stable_q) begin
      if (stay_cnt_q >= CntLast) begin
        stay_stable_d = stay_synced;
        stay_cnt_d    = '0;
      end else begin
        stay_cnt_d = stay_cnt_q + 8'd1;
      end
    end else begin
      stay_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_stable_q  <= 1'b1;
      stay_stable_q <= 1'b1;
      hit_cnt_q     <= '0;
      stay_cnt_q    <= '0;
    end else begin
      hit_stable_q  <= hit_stable_d;
      stay_stable_q <= stay_stable_d;
      hit_cnt_q     <= hit_cnt_d;
      stay_cnt_q    <= stay_cnt_d;
    end
  end

  assign hit_pressed  = ~hit_stable_q;
  assign stay_pressed = ~stay_stable_q;

  // A press seen while disabled is consumed here; the FSM then waits for a full release.
  always_comb begin
    state_d    = state_q;
    conflict_d = 1'b0;
    case (state_q)
      StWaitRelease: begin
        if (!hit_pressed && !stay_pressed) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (hit_pressed && stay_pressed) begin
          state_d    = StWaitRelease;
          conflict_d = 1'b1;
        end else if (hit_pressed || stay_pressed) begin
          if (!i_Enable) begin
            state_d = StWaitRelease;
          end else if (hit_pressed) begin
            state_d = StFireHit;
          end else begin
            state_d = StFireStay;
          end
        end
      end
      StFireHit:  state_d = StWaitRelease;
      StFireStay: state_d = StWaitRelease;
      default:    state_d = StWaitRelease;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StWaitRelease;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      conflict_q <= conflict_d;
    end
  end

  assign o_HitPulse  = (state_q == StFireHit);
  assign o_StayPulse = (state_q == StFireStay);
  assign o_Armed     = (state_q == StArmed);
  assign o_Conflict  = conflict_q;

endmodule

// File: tb/tb_hit_stay_conditioner.sv
// Bench for hit_stay_conditioner: table of press scenarios plus hand-written reset/enable
// sequences; expected pulse events are queued at stimulus time and matched against observed ones.
module tb_hit_stay_conditioner;

  localparam int unsigned SyncStages     = 2;
  localparam int unsigned DebounceCycles = 16;
  // Cycle index (relative to the drive cycle) at which the pulse is sampled on the negedge.
  localparam int Lat = SyncStages + DebounceCycles + 1;

  localparam int KHit  = 1;
  localparam int KStay = 2;
  localparam int KConf = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic hit_n   = 1'b1;
  logic stay_n  = 1'b1;
  logic en      = 1'b0;
  logic hit_pulse, stay_pulse, conflict, armed;

  hit_stay_conditioner #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(DebounceCycles)
  ) dut (
    .clk        (clk),
    .Reset_n    (rst_n),
    .i_Hit_n    (hit_n),
    .i_Stay_n   (stay_n),
    .i_Enable   (en),
    .o_HitPulse (hit_pulse),
    .o_StayPulse(stay_pulse),
    .o_Conflict (conflict),
    .o_Armed    (armed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  evt_t act_q[$];
  int   errors = 0;
  int   checks = 0;

  // Simultaneous pulses form a combined kind that can never match an expected event.
  always @(negedge clk) begin
    int k;
    k = 0;
    if (rst_n) begin
      if (hit_pulse)  k = k + KHit;
      if (stay_pulse) k = k + KStay;
      if (conflict)   k = k + KConf;
      if (k != 0) act_q.push_back('{k, cyc});
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    check({name, " event count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        check({name, " event kind"}, act_q[i].kind, exp_q[i].kind);
        check({name, " event cycle"}, act_q[i].cyc, exp_q[i].cyc);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  typedef struct {
    string name;
    int    hit_len;
    int    stay_off;
    int    stay_len;
    bit    enable;
    int    exp_kind;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int n;
    int len;
    en = v.enable;
    check({v.name, " armed before press"}, int'(armed), 1);
    n   = cyc;
    len = v.hit_len;
    if (v.stay_off + v.stay_len > len) len = v.stay_off + v.stay_len;
    if (v.exp_kind != 0) exp_q.push_back('{v.exp_kind, n + Lat});
    for (int t = 0; t < len; t++) begin
      hit_n  = (t < v.hit_len) ? 1'b0 : 1'b1;
      stay_n = (t >= v.stay_off && t < v.stay_off + v.stay_len) ? 1'b0 : 1'b1;
      tick();
    end
    hit_n  = 1'b1;
    stay_n = 1'b1;
    repeat (40) tick();
    drain(v.name);
  endtask

  initial begin
    int m;

    vecs.push_back('{"hit_hold",       255,  0,  0, 1'b1, KHit});
    vecs.push_back('{"hit_repress",     40,  0,  0, 1'b1, KHit});
    vecs.push_back('{"stay_glitch15",    0,  0, 15, 1'b1, 0});
    vecs.push_back('{"stay_16",          0,  0, 16, 1'b1, KStay});
    vecs.push_back('{"conflict",        40,  0, 40, 1'b1, KConf});
    vecs.push_back('{"stay_after_conf",  0,  0, 40, 1'b1, KStay});
    vecs.push_back('{"hit_disabled",    40,  0,  0, 1'b0, 0});
    vecs.push_back('{"hit_then_stay",   40, 25, 40, 1'b1, KHit});
    vecs.push_back('{"stay_then_hit",   30,  0,  0, 1'b1, KHit});
    vecs[8].hit_len  = 0;
    vecs[8].stay_len = 30;
    vecs[8].exp_kind = KStay;
    vecs.push_back('{"hit_stay_skew1",  40,  1, 40, 1'b1, KHit});

    // Reset with inputs toggling: outputs must stay quiet throughout.
    for (int i = 0; i < 6; i++) begin
      hit_n  = 1'($urandom_range(0, 1));
      stay_n = 1'($urandom_range(0, 1));
      tick();
      check("outputs in reset", int'({hit_pulse, stay_pulse, conflict, armed}), 0);
    end
    hit_n  = 1'b1;
    stay_n = 1'b1;
    rst_n  = 1'b1;
    check("armed before first edge", int'(armed), 0);
    tick();
    check("armed after one edge", int'(armed), 1);

    // Asynchronous reset must clear armed without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    check("async reset clears outputs", int'({hit_pulse, stay_pulse, conflict, armed}), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Enable rises while Hit is held: the discarded press must not fire late.
    en    = 1'b0;
    hit_n = 1'b0;
    repeat (30) tick();
    en = 1'b1;
    repeat (30) tick();
    hit_n = 1'b1;
    repeat (40) tick();
    drain("enable_late");
    m = cyc;
    exp_q.push_back('{KHit, m + Lat});
    hit_n = 1'b0;
    repeat (40) tick();
    hit_n = 1'b1;
    repeat (40) tick();
    drain("enable_repress");

    // Reset in the middle of debouncing; the held button counts as a fresh press afterwards.
    hit_n = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m = cyc;
    exp_q.push_back('{KHit, m + Lat});
    repeat (60) tick();
    hit_n = 1'b1;
    repeat (40) tick();
    drain("reset_mid_press");
    check("armed at end", int'(armed), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
